// File: rtl/sd_spi_card_emu.sv
// sd_spi_card_emu: SPI-mode SD card responder driving a byte-wide backing memory
module sd_spi_card_emu #(
  parameter int NCR_BYTES   = 1,
  parameter int ACMD41_BUSY = 2,
  parameter int READ_GAP    = 2,
  parameter int BUSY_BYTES  = 4
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  output logic        initialized,
  output logic [3:0]  status
);
  typedef enum logic [3:0] {
    HUNT, CMD_RX, RESP, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_HUNT, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_t;
  state_t      state_q, state_d;
  logic        sclk_q, rise, fall, tx_st, last;
  logic [5:0]  bit_q, bit_d;
  logic [9:0]  byte_q, byte_d;
  logic [44:0] sh_q, sh_d;
  logic [45:0] cmd;
  logic [6:0]  tx_q, tx_d;
  logic [7:0]  tx_byte, r1_q, r1_d, acnt_q, acnt_d, rd_q, wdat_q, wdat_d;
  logic        miso_q, miso_d, app_q, app_d, init_q, init_d;
  logic        rd_en_q, rd_en_d, wr_en_q, wr_en_d, rd_pend_q;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] arg_q, arg_d, addr_q, addr_d;

  assign rise    = sclk & ~sclk_q;
  assign fall    = ~sclk & sclk_q;
  assign cmd     = {sh_q, mosi};
  assign last    = bit_q == 6'd7;
  assign tx_st   = state_q inside {RESP, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC, WR_RESP, WR_BUSY};
  assign tx_byte = state_q == RESP     ? (byte_q < 10'(NCR_BYTES) ? 8'hFF : r1_q) :
                   state_q == RD_TOKEN ? 8'hFE :
                   state_q == RD_DATA  ? rd_q  :
                   state_q == WR_RESP  ? 8'h05 :
                   state_q == WR_BUSY  ? 8'h00 : 8'hFF;

  // next state: shift MISO on falling edges, sample MOSI on rising edges, cs overrides all
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    r1_d    = r1_q;
    mode_d  = mode_q;
    arg_d   = arg_q;
    app_d   = app_q;
    acnt_d  = acnt_q;
    init_d  = init_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    if (cs) begin
      state_d = HUNT;
      miso_d  = 1'b1;
      bit_d   = '0;
      byte_d  = '0;
    end else if (fall && tx_st) begin
      miso_d = bit_q == 6'd0 ? tx_byte[7] : tx_q[6];
      tx_d   = bit_q == 6'd0 ? tx_byte[6:0] : {tx_q[5:0], 1'b1};
      bit_d  = last ? 6'd0 : bit_q + 6'd1;
      byte_d = last ? byte_q + 10'd1 : byte_q;
      if (bit_q == 6'd0 && (state_q == RD_TOKEN || (state_q == RD_DATA && byte_q != 10'd511))) begin
        rd_en_d = 1'b1;
        addr_d  = arg_q + (state_q == RD_TOKEN ? 32'd0 : 32'(byte_q) + 32'd1);
      end
      if (last)
        case (state_q)
          RESP: if (byte_q == 10'(NCR_BYTES)) begin
            state_d = mode_q == 2'd1 ? RD_GAP : mode_q == 2'd2 ? WR_HUNT : HUNT;
            byte_d  = '0;
          end
          RD_GAP: if (byte_q == 10'(READ_GAP - 1)) begin
            state_d = RD_TOKEN;
            byte_d  = '0;
          end
          RD_TOKEN: begin
            state_d = RD_DATA;
            byte_d  = '0;
          end
          RD_DATA: if (byte_q == 10'd511) begin
            state_d = RD_CRC;
            byte_d  = '0;
          end
          RD_CRC: if (byte_q == 10'd1) state_d = HUNT;
          WR_RESP: begin
            state_d = WR_BUSY;
            byte_d  = '0;
          end
          WR_BUSY: if (byte_q == 10'(BUSY_BYTES - 1)) state_d = HUNT;
          default: ;
        endcase
    end else if (fall && (state_q == HUNT || state_q == WR_HUNT)) begin
      miso_d = 1'b1;
    end else if (rise) begin
      sh_d = cmd[44:0];
      case (state_q)
        HUNT: if (!mosi) begin
          state_d = CMD_RX;
          bit_d   = 6'd1;
        end
        CMD_RX: begin
          bit_d = bit_q + 6'd1;
          if (bit_q == 6'd47) begin
            state_d = RESP;
            bit_d   = '0;
            byte_d  = '0;
            arg_d   = cmd[39:8];
            app_d   = cmd[45:40] == 6'd55;
            mode_d  = 2'd0;
            r1_d    = {5'b0, 1'b1, 1'b0, ~init_q};
            if (cmd[45:40] == 6'd0) begin
              init_d = 1'b0;
              acnt_d = '0;
              r1_d   = 8'h01;
            end else if (cmd[45:40] == 6'd55) begin
              r1_d = {7'b0, ~init_q};
            end else if (cmd[45:40] == 6'd41 && app_q) begin
              acnt_d = acnt_q < 8'(ACMD41_BUSY) ? acnt_q + 8'd1 : acnt_q;
              init_d = acnt_q >= 8'(ACMD41_BUSY);
              r1_d   = acnt_q < 8'(ACMD41_BUSY) ? 8'h01 : 8'h00;
            end else if ((cmd[45:40] == 6'd17 || cmd[45:40] == 6'd24) && init_q) begin
              r1_d   = cmd[16:8] != 9'd0 ? 8'h40 : 8'h00;
              mode_d = cmd[16:8] != 9'd0 ? 2'd0 : cmd[45:40] == 6'd17 ? 2'd1 : 2'd2;
            end
          end
        end
        WR_HUNT: if (!mosi) begin
          state_d = WR_DATA;
          bit_d   = '0;
          byte_d  = '0;
        end
        WR_DATA, WR_CRC: begin
          bit_d = last ? 6'd0 : bit_q + 6'd1;
          if (last) begin
            byte_d = byte_q + 10'd1;
            if (state_q == WR_DATA) begin
              wr_en_d = 1'b1;
              wdat_d  = cmd[7:0];
              addr_d  = arg_q + 32'(byte_q);
            end
            if ((state_q == WR_DATA && byte_q == 10'd511) || (state_q == WR_CRC && byte_q == 10'd1)) begin
              state_d = state_q == WR_DATA ? WR_CRC : WR_RESP;
              byte_d  = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // state registers; read data is captured the cycle after the strobe reaches memory
  always_ff @(posedge clk_25MHz) begin
    sclk_q <= sclk;
    if (reset) begin
      state_q   <= HUNT;
      bit_q     <= '0;
      byte_q    <= '0;
      sh_q      <= '0;
      tx_q      <= '1;
      miso_q    <= 1'b1;
      r1_q      <= '0;
      mode_q    <= '0;
      arg_q     <= '0;
      app_q     <= 1'b0;
      acnt_q    <= '0;
      init_q    <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      r1_q      <= r1_d;
      mode_q    <= mode_d;
      arg_q     <= arg_d;
      app_q     <= app_d;
      acnt_q    <= acnt_d;
      init_q    <= init_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      rd_pend_q <= rd_en_q;
      if (rd_pend_q) rd_q <= mem_rd_data;
    end
  end

  assign miso        = miso_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wdat_q;
  assign initialized = init_q;
  assign status      = state_q;
endmodule

// File: tb/tb_sd_spi_card_emu.sv
// tb_sd_spi_card_emu: scoreboard bench for the SPI-mode SD card responder
module tb_sd_spi_card_emu;
  logic        clk = 1'b0, reset = 1'b1, cs = 1'b1, sclk = 1'b0, mosi = 1'b1, preload = 1'b1;
  logic        miso, mem_rd_en, mem_wr_en, initialized;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rd_data = 8'h00, mem_wr_data;
  logic [3:0]  status;
  logic [7:0]  mem [0:4095];
  logic [7:0]  exp_q [$];
  int          pass_cnt = 0, chk_cnt = 0, rd_pulses = 0, overlap = 0, unstable = 0;
  logic        sclk_h = 1'b0, miso_h = 1'b1, quiet_h = 1'b0;

  always #5 clk = ~clk;

  sd_spi_card_emu dut (
    .clk_25MHz(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .initialized(initialized), .status(status)
  );

  // synchronous backing memory plus strobe-overlap and MISO-stability monitors
  always @(posedge clk) begin
    if (preload)
      for (int i = 0; i < 4096; i++) mem[i] <= (i >= 'h200 && i < 'h400) ? 8'(i) : 8'h00;
    else if (mem_wr_en) mem[mem_addr[11:0]] <= mem_wr_data;
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr[11:0]];
      rd_pulses   <= rd_pulses + 1;
    end
    if (mem_rd_en && mem_wr_en) overlap <= overlap + 1;
    if (sclk_h && sclk && quiet_h && !cs && !reset && miso !== miso_h) unstable <= unstable + 1;
    sclk_h  <= sclk;
    miso_h  <= miso;
    quiet_h <= !cs && !reset;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      sclk = 1'b0;
      mosi = tx[i];
      @(negedge clk);
      @(negedge clk);
      sclk  = 1'b1;
      rx[i] = miso;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] rx;
    logic [47:0] c;
    c = {2'b01, idx, arg, (idx == 6'd0) ? 8'h95 : 8'h01};
    for (int i = 5; i >= 0; i--) xfer(c[i*8 +: 8], rx);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++; if (miso !== 1'b1) $display("FAIL reset_miso got %b exp 1", miso); else pass_cnt++;
    chk_cnt++; if (status !== 4'd0) $display("FAIL reset_status got %0d exp 0", status); else pass_cnt++;
    chk_cnt++; if (initialized !== 1'b0) $display("FAIL reset_init got %b exp 0", initialized); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 32'd0) $display("FAIL reset_addr got %h exp 0", mem_addr); else pass_cnt++;
    chk_cnt++; if ({mem_rd_en, mem_wr_en} !== 2'b00) $display("FAIL reset_strobes got %b exp 00", {mem_rd_en, mem_wr_en}); else pass_cnt++;
    chk_cnt++; if (mem_wr_data !== 8'h00) $display("FAIL reset_wdata got %h exp 00", mem_wr_data); else pass_cnt++;
    reset   = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic test_cmd0();
    logic [7:0] rx, e;
    send_cmd(6'd0, 32'd0);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    repeat (4) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL cmd0_resp got %h exp %h", rx, e); else pass_cnt++;
    end
    chk_cnt++; if (initialized !== 1'b0) $display("FAIL cmd0_init got %b exp 0", initialized); else pass_cnt++;
  endtask

  task automatic test_uninit();
    logic [7:0] rx, e;
    send_cmd(6'd17, 32'h200);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h05);
    repeat (4) exp_q.push_back(8'hFF);
    repeat (6) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL cmd17_uninit got %h exp %h", rx, e); else pass_cnt++;
    end
    send_cmd(6'd41, 32'd0);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h05); exp_q.push_back(8'hFF);
    repeat (3) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL cmd41_noapp got %h exp %h", rx, e); else pass_cnt++;
    end
  endtask

  task automatic test_acmd41();
    logic [7:0] rx, e;
    for (int k = 0; k < 3; k++) begin
      send_cmd(6'd55, 32'd0);
      exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
      repeat (2) begin
        xfer(8'hFF, rx); e = exp_q.pop_front();
        chk_cnt++; if (rx !== e) $display("FAIL cmd55_%0d got %h exp %h", k, rx, e); else pass_cnt++;
      end
      send_cmd(6'd41, 32'h4000_0000);
      exp_q.push_back(8'hFF); exp_q.push_back(k < 2 ? 8'h01 : 8'h00);
      repeat (2) begin
        xfer(8'hFF, rx); e = exp_q.pop_front();
        chk_cnt++; if (rx !== e) $display("FAIL acmd41_%0d got %h exp %h", k, rx, e); else pass_cnt++;
      end
    end
    chk_cnt++; if (initialized !== 1'b1) $display("FAIL acmd41_init got %b exp 1", initialized); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [7:0] rx, e;
    send_cmd(6'd17, 32'h201);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h40);
    repeat (4) exp_q.push_back(8'hFF);
    repeat (6) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL cmd17_misaligned got %h exp %h", rx, e); else pass_cnt++;
    end
    send_cmd(6'd8, 32'h1AA);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h04);
    repeat (4) exp_q.push_back(8'hFF);
    repeat (6) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL cmd8_illegal got %h exp %h", rx, e); else pass_cnt++;
    end
  endtask

  task automatic test_read();
    logic [7:0] rx, e;
    int r0, bad;
    r0  = rd_pulses;
    bad = 0;
    send_cmd(6'd17, 32'h200);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFE);
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
    repeat (3) exp_q.push_back(8'hFF);
    repeat (520) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++;
      if (rx !== e) begin
        bad++;
        if (bad < 8) $display("FAIL read_byte got %h exp %h", rx, e);
      end else pass_cnt++;
    end
    chk_cnt++; if (rd_pulses - r0 !== 512) $display("FAIL read_pulses got %0d exp 512", rd_pulses - r0); else pass_cnt++;
  endtask

  task automatic test_write();
    logic [7:0] rx, e;
    int bad;
    bad = 0;
    send_cmd(6'd24, 32'h400);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    repeat (2) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL write_r1 got %h exp %h", rx, e); else pass_cnt++;
    end
    repeat (515) exp_q.push_back(8'hFF);
    for (int i = -1; i < 514; i++) begin
      xfer(i < 0 ? 8'hFE : i < 512 ? 8'hA5 ^ 8'(i) : 8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL write_idle_miso idx %0d got %h exp %h", i, rx, e); else pass_cnt++;
    end
    exp_q.push_back(8'h05);
    repeat (4) exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    repeat (6) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL write_resp_busy got %h exp %h", rx, e); else pass_cnt++;
    end
    for (int i = 0; i < 512; i++) if (mem['h400 + i] !== (8'hA5 ^ 8'(i))) bad++;
    chk_cnt++; if (bad !== 0) $display("FAIL write_mem bad bytes got %0d exp 0", bad); else pass_cnt++;
  endtask

  task automatic test_abort_read();
    logic [7:0] rx, e;
    send_cmd(6'd17, 32'h200);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFE);
    for (int i = 0; i < 100; i++) exp_q.push_back(8'(i));
    repeat (105) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL abort_pre got %h exp %h", rx, e); else pass_cnt++;
    end
    @(negedge clk);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (miso !== 1'b1) $display("FAIL abort_miso got %b exp 1", miso); else pass_cnt++;
    chk_cnt++; if (status !== 4'd0) $display("FAIL abort_status got %0d exp 0", status); else pass_cnt++;
    exp_q.push_back(8'hFF);
    xfer(8'h00, rx); e = exp_q.pop_front();
    chk_cnt++; if (rx !== e) $display("FAIL abort_cs_high got %h exp %h", rx, e); else pass_cnt++;
    chk_cnt++; if (status !== 4'd0) $display("FAIL abort_no_sample got %0d exp 0", status); else pass_cnt++;
    @(negedge clk);
    cs = 1'b0;
    test_read();
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] rx, e;
    send_cmd(6'd24, 32'h800);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    repeat (2) begin
      xfer(8'hFF, rx); e = exp_q.pop_front();
      chk_cnt++; if (rx !== e) $display("FAIL rstwr_r1 got %h exp %h", rx, e); else pass_cnt++;
    end
    xfer(8'hFE, rx);
    for (int i = 0; i < 50; i++) xfer(8'hA5 ^ 8'(i), rx);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++; if (miso !== 1'b1) $display("FAIL rstwr_miso got %b exp 1", miso); else pass_cnt++;
    chk_cnt++; if (status !== 4'd0) $display("FAIL rstwr_status got %0d exp 0", status); else pass_cnt++;
    chk_cnt++; if (initialized !== 1'b0) $display("FAIL rstwr_init got %b exp 0", initialized); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 32'd0) $display("FAIL rstwr_addr got %h exp 0", mem_addr); else pass_cnt++;
    chk_cnt++; if ({mem_rd_en, mem_wr_en} !== 2'b00) $display("FAIL rstwr_strobes got %b exp 00", {mem_rd_en, mem_wr_en}); else pass_cnt++;
    chk_cnt++; if (mem_wr_data !== 8'h00) $display("FAIL rstwr_wdata got %h exp 00", mem_wr_data); else pass_cnt++;
    chk_cnt++; if (mem['h800 + 48] !== (8'hA5 ^ 8'd48)) $display("FAIL rstwr_kept got %h exp %h", mem['h800 + 48], 8'hA5 ^ 8'd48); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_invariants();
    chk_cnt++; if (overlap !== 0) $display("FAIL strobe_overlap got %0d exp 0", overlap); else pass_cnt++;
    chk_cnt++; if (unstable !== 0) $display("FAIL miso_high_phase_changes got %0d exp 0", unstable); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_uninit();
    test_acmd41();
    test_errors();
    test_read();
    test_write();
    test_abort_read();
    test_reset_mid_write();
    test_invariants();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
